vip_axi4_wr_responder: RTL

VIP_AXI4_WR_RESPONDER -- requirements
Module: vip_axi4_wr_responder

---
 rtl/vip_axi4_pkg.sv | 18 +
 rtl/vip_axi4_wr_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vip_axi4_pkg.sv
// Shared configuration type for the AXI4 VIP blocks.
// A width field left at zero selects the built-in default for that width.
package vip_axi4_pkg;

  typedef struct packed {
    logic [31:0] VIP_AXI4_ID_WIDTH_P;
    logic [31:0] VIP_AXI4_ADDR_WIDTH_P;
    logic [31:0] VIP_AXI4_DATA_WIDTH_P;
    logic [31:0] VIP_AXI4_STRB_WIDTH_P;
    logic [31:0] VIP_AXI4_USER_WIDTH_P;
  } vip_axi4_cfg_t;

  // Returns the configured width, or the fallback when the field is left at zero
  function automatic int width_or(input logic [31:0] w, input int dflt);
    return (w == 32'd0) ? dflt : int'(w);
  endfunction

endpackage

// File: rtl/vip_axi4_wr_responder.sv
// AXI4 write-channel responder: accepts one burst at a time, turns every
// accepted beat into a registered memory write strobe and answers with a
// single B response (OKAY, or SLVERR when the burst was malformed).
module vip_axi4_wr_responder
  import vip_axi4_pkg::*;
#(
  parameter vip_axi4_cfg_t CFG_P = '{default: '0}
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [width_or(CFG_P.VIP_AXI4_ID_WIDTH_P, 4)-1:0]      awid,
  input  logic [width_or(CFG_P.VIP_AXI4_ADDR_WIDTH_P, 32)-1:0]   awaddr,
  input  logic [7:0]                                             awlen,
  input  logic [2:0]                                             awsize,
  input  logic [1:0]                                             awburst,
  input  logic                                                   awvalid,
  output logic                                                   awready,
  input  logic [width_or(CFG_P.VIP_AXI4_DATA_WIDTH_P, 32)-1:0]   wdata,
  input  logic [width_or(CFG_P.VIP_AXI4_STRB_WIDTH_P,
                         width_or(CFG_P.VIP_AXI4_DATA_WIDTH_P, 32) / 8)-1:0] wstrb,
  input  logic                                                   wlast,
  input  logic                                                   wvalid,
  output logic                                                   wready,
  output logic [width_or(CFG_P.VIP_AXI4_ID_WIDTH_P, 4)-1:0]      bid,
  output logic [1:0]                                             bresp,
  output logic [width_or(CFG_P.VIP_AXI4_USER_WIDTH_P, 1)-1:0]    buser,
  output logic                                                   bvalid,
  input  logic                                                   bready,
  output logic                                                   mem_wr_en,
  output logic [width_or(CFG_P.VIP_AXI4_ADDR_WIDTH_P, 32)-1:0]   mem_addr,
  output logic [width_or(CFG_P.VIP_AXI4_DATA_WIDTH_P, 32)-1:0]   mem_wdata,
  output logic [width_or(CFG_P.VIP_AXI4_STRB_WIDTH_P,
                         width_or(CFG_P.VIP_AXI4_DATA_WIDTH_P, 32) / 8)-1:0] mem_wstrb
);

  localparam int ID_W   = width_or(CFG_P.VIP_AXI4_ID_WIDTH_P, 4);
  localparam int ADDR_W = width_or(CFG_P.VIP_AXI4_ADDR_WIDTH_P, 32);
  localparam int DATA_W = width_or(CFG_P.VIP_AXI4_DATA_WIDTH_P, 32);
  localparam int STRB_W = width_or(CFG_P.VIP_AXI4_STRB_WIDTH_P, DATA_W / 8);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_cnt;
  logic              err_q;
  logic              aw_err_q;

  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              last_beat;
  logic              beat_err;
  logic              err_final;
  logic              aw_err;
  logic [ADDR_W-1:0] size_bytes;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] addr_next;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign last_beat = (beat_cnt == len_q);
  // wlast must be high exactly on the final beat, low on every other one
  assign beat_err  = (wlast != last_beat);
  assign err_final = err_q || beat_err;
  assign buser     = '0;

  // Burst legality that can be judged from the AW channel alone
  always_comb begin
    aw_err = 1'b0;
    if (awburst == BURST_RSVD) begin
      aw_err = 1'b1;
    end
    if ((awburst == BURST_WRAP) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
      aw_err = 1'b1;
    end
    if ((32'd8 << awsize) > 32'(DATA_W)) begin
      aw_err = 1'b1;
    end
  end

  // Address of the beat after the current one, by burst type
  always_comb begin
    size_bytes = ADDR_W'(1) << size_q;
    wrap_mask  = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + size_bytes) & wrap_mask);
      default:     addr_next = addr_q + size_bytes;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: one burst in flight, AW then W beats then B
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (aw_hs) state_next = DATA;
      DATA: if (w_hs && last_beat) state_next = RESP;
      RESP: if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they are all low in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      awready <= (state_next == IDLE);
      wready  <= (state_next == DATA);
      bvalid  <= (state_next == RESP);
    end
  end

  // B payload captured on entry to RESP and held until the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bid   <= '0;
      bresp <= RESP_OKAY;
    end else if ((state == DATA) && (state_next == RESP)) begin
      bid   <= id_q;
      bresp <= err_final ? RESP_SLVERR : RESP_OKAY;
    end else if (state_next != RESP) begin
      bid   <= '0;
      bresp <= RESP_OKAY;
    end
  end

  // Burst context: latched at AW, address and beat count advance per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      aw_err_q <= 1'b0;
    end else if (aw_hs) begin
      id_q     <= awid;
      addr_q   <= awaddr;
      len_q    <= awlen;
      size_q   <= awsize;
      burst_q  <= awburst;
      beat_cnt <= '0;
      err_q    <= aw_err;
      aw_err_q <= aw_err;
    end else if (w_hs) begin
      addr_q   <= addr_next;
      beat_cnt <= beat_cnt + 8'd1;
      err_q    <= err_final;
    end
  end

  // Memory write port: one registered pulse per beat, suppressed for AW-time errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_wr_en <= w_hs && !aw_err_q;
      if (w_hs) begin
        mem_addr  <= addr_q;
        mem_wdata <= wdata;
        mem_wstrb <= wstrb;
      end
    end
  end

endmodule
